// File: rtl/kpscan.sv
// 4x4 keypad scanner: column-multiplexed row sampling, per-key debounce and a
// small first-word-fall-through FIFO of press/release events with overflow flag.
module kpscan #(
  parameter int CLK_DIV        = 80000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int LGFIFO         = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [3:0]  i_kp_row,
  output logic [3:0]  o_kp_col,
  output logic [15:0] o_keys,
  output logic        o_valid,
  output logic [4:0]  o_event,
  input  logic        i_ack,
  output logic        o_overflow,
  input  logic        i_clr
);

  localparam int                 DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [2:0]         DB_LIMIT = 3'(DEBOUNCE_SCANS);
  localparam int                 DEPTH    = 1 << LGFIFO;
  localparam logic [LGFIFO:0]    FULL_CNT = (LGFIFO + 1)'(DEPTH);

  typedef enum logic {S_DWELL, S_EVAL} state_t;

  state_t            state_q, state_d;
  logic [1:0]        col_q, col_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [3:0]        key_q, key_d;
  logic [3:0]        kp_col_q, kp_col_d;
  logic              sample, eval;

  logic [3:0]        row_meta, row_sync;
  logic [15:0]       raw_q;
  logic [15:0]       keys_q;
  logic [2:0]        cnt_q [16];

  logic              key_diff, flip;
  logic [2:0]        cnt_next;
  logic [4:0]        push_data;

  logic [4:0]        mem [DEPTH];
  logic [LGFIFO-1:0] wr_ptr, rd_ptr;
  logic [LGFIFO:0]   count;
  logic              full, pop, push_ok, drop;
  logic              overflow_q;

  // Rows idle high (pulled up), so the synchronizer resets to "no key".
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      row_meta <= 4'hf;
      row_sync <= 4'hf;
    end else begin
      row_meta <= i_kp_row;
      row_sync <= row_meta;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_DWELL;
      col_q    <= 2'd0;
      div_q    <= '0;
      key_q    <= 4'd0;
      kp_col_q <= 4'hf;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      div_q    <= div_d;
      key_q    <= key_d;
      kp_col_q <= kp_col_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    div_d   = div_q;
    key_d   = key_q;
    sample  = 1'b0;
    eval    = 1'b0;
    unique case (state_q)
      S_DWELL: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sample = 1'b1;
          if (col_q == 2'd3) begin
            col_d   = 2'd0;
            key_d   = 4'd0;
            state_d = S_EVAL;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_EVAL: begin
        eval = 1'b1;
        if (key_q == 4'd15) begin
          key_d   = 4'd0;
          state_d = S_DWELL;
        end else begin
          key_d = key_q + 4'd1;
        end
      end
      default: state_d = S_DWELL;
    endcase
    // Column drive is registered so it reads 4'hf throughout reset.
    kp_col_d = (state_d == S_DWELL) ? ~(4'b0001 << col_d) : 4'hf;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      raw_q <= '0;
    end else if (sample) begin
      for (int r = 0; r < 4; r++) raw_q[{2'(r), col_q}] <= ~row_sync[r];
    end
  end

  assign key_diff  = raw_q[key_q] ^ keys_q[key_q];
  assign cnt_next  = cnt_q[key_q] + 3'd1;
  assign flip      = eval && key_diff && (cnt_next == DB_LIMIT);
  assign push_data = {~keys_q[key_q], key_q};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      keys_q <= '0;
      for (int k = 0; k < 16; k++) cnt_q[k] <= 3'd0;
    end else if (eval) begin
      if (!key_diff) begin
        cnt_q[key_q] <= 3'd0;
      end else if (flip) begin
        keys_q[key_q] <= ~keys_q[key_q];
        cnt_q[key_q]  <= 3'd0;
      end else begin
        cnt_q[key_q] <= cnt_next;
      end
    end
  end

  // A pop frees the full slot in the same cycle, so a coincident push still lands.
  assign full    = (count == FULL_CNT);
  assign pop     = (count != '0) && i_ack;
  assign push_ok = flip && (!full || pop);
  assign drop    = flip && full && !pop;

  // NOTE: FIFO storage has no reset; o_event is gated by o_valid so stale words never escape.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)       overflow_q <= 1'b1;
      else if (i_clr) overflow_q <= 1'b0;
    end
  end

  assign o_kp_col   = kp_col_q;
  assign o_keys     = keys_q;
  assign o_valid    = (count != '0);
  assign o_event    = o_valid ? mem[rd_ptr] : 5'd0;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_kpscan.sv
// Directed bench for kpscan: column sweep table, debounce latency, bounce
// rejection, event ordering, FIFO overflow/clear and reset mid-evaluation.
module tb_kpscan;

  logic        clk;
  logic        rst_n;
  logic [3:0]  kp_row;
  logic [3:0]  kp_col;
  logic [15:0] keys;
  logic        valid;
  logic [4:0]  ev;
  logic        ack;
  logic        overflow;
  logic        clr;
  logic [15:0] pressed;

  int checks_total  = 0;
  int checks_passed = 0;

  kpscan #(.CLK_DIV(8), .DEBOUNCE_SCANS(2), .LGFIFO(2)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_kp_row   (kp_row),
    .o_kp_col   (kp_col),
    .o_keys     (keys),
    .o_valid    (valid),
    .o_event    (ev),
    .i_ack      (ack),
    .o_overflow (overflow),
    .i_clr      (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: a pressed key shorts its row to the driven-low column.
  always_comb begin
    kp_row = 4'hf;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[4*r+c] && !kp_col[c]) kp_row[r] = 1'b0;
  end

  typedef struct {
    int         adv;
    logic [3:0] col;
  } col_vec_t;

  col_vec_t col_tab [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns 1 time unit after the edge on which the column-0 dwell begins.
  task automatic wait_dwell_start();
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    prev  = kp_col;
    for (int i = 0; i < 200 && !found; i++) begin
      tick(1);
      if (prev == 4'hf && kp_col == 4'he) found = 1'b1;
      prev = kp_col;
    end
    if (!found) begin
      checks_total++;
      $display("FAIL dwell_start: got timeout expected column-0 dwell within 200 cycles");
    end
  endtask

  task automatic pop_expect(input string name, input logic [4:0] exp_ev);
    check({name, "_valid"}, 32'(valid), 32'd1);
    check(name, 32'(ev), 32'(exp_ev));
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col"},      32'(kp_col),   32'hf);
    check({tag, "_keys"},     32'(keys),     32'h0);
    check({tag, "_valid"},    32'(valid),    32'd0);
    check({tag, "_event"},    32'(ev),       32'h0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    // Cycle offsets after reset release: first dwell shows 7 cycles, then 8 each, EVAL 16.
    col_tab[0]  = '{1,  4'he};
    col_tab[1]  = '{6,  4'he};
    col_tab[2]  = '{1,  4'hd};
    col_tab[3]  = '{7,  4'hd};
    col_tab[4]  = '{1,  4'hb};
    col_tab[5]  = '{8,  4'h7};
    col_tab[6]  = '{7,  4'h7};
    col_tab[7]  = '{1,  4'hf};
    col_tab[8]  = '{15, 4'hf};
    col_tab[9]  = '{1,  4'he};
    col_tab[10] = '{8,  4'hd};

    rst_n   = 1'b0;
    ack     = 1'b0;
    clr     = 1'b0;
    pressed = '0;

    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick(col_tab[i].adv);
      check($sformatf("col_sweep_%0d", i), 32'(kp_col), 32'(col_tab[i].col));
    end

    // Key 6 press: event appears on the EVAL edge of the second sweep, not before.
    wait_dwell_start();
    pressed = 16'h0040;
    tick(86);
    check("press6_early_valid", 32'(valid), 32'd0);
    check("press6_early_keys",  32'(keys),  32'h0);
    tick(1);
    check("press6_keys", 32'(keys), 32'h0040);
    pop_expect("press6_event", 5'h16);
    check("press6_drained", 32'(valid), 32'd0);
    wait_dwell_start();
    wait_dwell_start();
    pressed = '0;
    tick(86);
    check("rel6_early_valid", 32'(valid), 32'd0);
    check("rel6_early_keys",  32'(keys),  32'h0040);
    tick(1);
    check("rel6_keys", 32'(keys), 32'h0);
    pop_expect("rel6_event", 5'h06);

    // Bounce: alternating sweeps never accumulate two consecutive differences.
    for (int rep = 0; rep < 4; rep++) begin
      wait_dwell_start();
      pressed = 16'h0040;
      wait_dwell_start();
      pressed = '0;
    end
    wait_dwell_start();
    wait_dwell_start();
    check("bounce_valid", 32'(valid), 32'd0);
    check("bounce_keys",  32'(keys),  32'h0);

    // Two keys in one sweep queue in ascending index order.
    wait_dwell_start();
    pressed = 16'h1008;
    tick(96);
    check("dual_keys", 32'(keys), 32'h1008);
    pop_expect("dual_first",  5'h13);
    pop_expect("dual_second", 5'h1c);
    check("dual_drained", 32'(valid), 32'd0);
    wait_dwell_start();
    pressed = '0;
    tick(96);
    pop_expect("dual_rel_first",  5'h03);
    pop_expect("dual_rel_second", 5'h0c);

    // Ack while empty must not disturb the FIFO.
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("ack_empty_valid", 32'(valid), 32'd0);

    // Five presses in one sweep: key 15 is the fifth push and gets dropped.
    wait_dwell_start();
    pressed = 16'h8423;
    tick(96);
    check("ovf_keys", 32'(keys),     32'h8423);
    check("ovf_flag", 32'(overflow), 32'd1);
    pop_expect("ovf_ev0", 5'h10);
    pop_expect("ovf_ev1", 5'h11);
    pop_expect("ovf_ev2", 5'h15);
    pop_expect("ovf_ev3", 5'h1a);
    check("ovf_drained", 32'(valid),    32'd0);
    check("ovf_sticky",  32'(overflow), 32'd1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Release all five: FIFO fills with keys 0,1,5,10 and the key-15 push meets an ack.
    wait_dwell_start();
    pressed = '0;
    tick(48);
    tick(47);
    check("coinc_full_valid", 32'(valid),    32'd1);
    check("coinc_head",       32'(ev),       32'h00);
    check("coinc_pre_ovf",    32'(overflow), 32'd0);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("coinc_ovf", 32'(overflow), 32'd0);
    pop_expect("coinc_ev1", 5'h01);
    pop_expect("coinc_ev2", 5'h05);
    pop_expect("coinc_ev3", 5'h0a);
    pop_expect("coinc_ev4", 5'h0f);
    check("coinc_drained", 32'(valid), 32'd0);
    check("coinc_keys",    32'(keys),  32'h0);

    // Asynchronous reset in the middle of EVAL with an event pending.
    wait_dwell_start();
    pressed = 16'h0040;
    tick(96);
    check("pre_rst_valid", 32'(valid), 32'd1);
    tick(35);
    check("pre_rst_in_eval", 32'(kp_col), 32'hf);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    pressed = '0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("post_rst_col", 32'(kp_col), 32'he);
    check("post_rst_valid", 32'(valid), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
